// File: rtl/non_restoring_divider_m_if.sv
// Request/result bundle for the non-restoring divider: valid/ready in both
// directions, destination tag, and pipeline kill.
interface non_restoring_divider_m_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [1:0]       i_op;
    logic             i_word;
    logic [XLEN-1:0]  i_dividend;
    logic [XLEN-1:0]  i_divisor;
    logic [TAG_W-1:0] i_tag;
    logic             i_kill;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_busy;

    modport slave (
        input  i_valid, i_op, i_word, i_dividend, i_divisor, i_tag, i_kill, i_ready,
        output o_ready, o_valid, o_result, o_tag, o_busy
    );

    modport master (
        output i_valid, i_op, i_word, i_dividend, i_divisor, i_tag, i_kill, i_ready,
        input  o_ready, o_valid, o_result, o_tag, o_busy
    );
endinterface

// File: rtl/non_restoring_divider_m.sv
// Multi-cycle non-restoring divider for RV M-extension DIV/DIVU/REM/REMU (+W).
// Optional NON_RESTORING_EARLY_OUT_EN skips the iteration for trivial operands.
module non_restoring_divider_m #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input logic                      i_non_restoring_clk,
    input logic                      i_non_restoring_rstn,
    non_restoring_divider_m_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIVIDE, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             word_q, word_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN:0]    a_q, a_d;
    logic [XLEN-1:0]  q_q, q_d;
    logic [XLEN-1:0]  m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [XLEN-1:0]  aeff_q, aeff_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             early_q, early_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] otag_q, otag_d;

    logic             is_word, is_signed, a_neg, b_neg, accept;
    logic [XLEN-1:0]  a_eff, b_eff, min_val, mag_a, mag_b;
    logic [XLEN:0]    a_sh, a_new;
    logic [XLEN-1:0]  a_fix, q_s, r_s, fix_res;

    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_ready  = i_non_restoring_rstn &
                          ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.i_ready));
    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_result = result_q;
    assign bus.o_tag    = otag_q;
    assign accept       = bus.i_valid & bus.o_ready & ~bus.i_kill;

    // Operand conditioning: W ops re-extend bits [31:0] to the full width.
    always_comb begin
        is_word   = (XLEN == 64) & word_q;
        is_signed = ~op_q[0];
        a_eff     = rs1_q;
        b_eff     = rs2_q;
        min_val   = '0;
        min_val[XLEN-1] = 1'b1;
        if (is_word) begin
            for (int i = 32; i < XLEN; i++) begin
                a_eff[i]   = is_signed & rs1_q[31];
                b_eff[i]   = is_signed & rs2_q[31];
                min_val[i] = 1'b1;
            end
            min_val[31] = 1'b1;
        end
        a_neg = is_signed & a_eff[XLEN-1];
        b_neg = is_signed & b_eff[XLEN-1];
        mag_a = a_neg ? -a_eff : a_eff;
        mag_b = b_neg ? -b_eff : b_eff;
    end

    // One non-restoring step; A carries an extra sign bit.
    always_comb begin
        a_sh  = {a_q[XLEN-1:0], q_q[XLEN-1]};
        a_new = a_q[XLEN] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
    end

    // Final correction, sign application, and special-case override.
    always_comb begin
        a_fix = a_q[XLEN] ? (a_q[XLEN-1:0] + m_q) : a_q[XLEN-1:0];
        q_s   = qneg_q ? -q_q : q_q;
        r_s   = rneg_q ? -a_fix : a_fix;
        fix_res = op_q[1] ? r_s : q_s;
        if (div0_q)
            fix_res = op_q[1] ? aeff_q : '1;
        else if (ovf_q)
            fix_res = op_q[1] ? '0 : aeff_q;
        else if (early_q)
            fix_res = op_q[1] ? aeff_q : '0;
        if (is_word) begin
            for (int i = 32; i < XLEN; i++) fix_res[i] = fix_res[31];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        tag_d    = tag_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        aeff_d   = aeff_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        early_d  = early_q;
        result_d = result_q;
        otag_d   = otag_q;

        if (accept) begin
            op_d    = bus.i_op;
            word_d  = bus.i_word;
            tag_d   = bus.i_tag;
            rs1_d   = bus.i_dividend;
            rs2_d   = bus.i_divisor;
            state_d = S_PREP;
        end

        unique case (state_q)
            S_IDLE: ;
            S_PREP: begin
                aeff_d = a_eff;
                qneg_d = a_neg ^ b_neg;
                rneg_d = a_neg;
                a_d    = '0;
                q_d    = is_word ? (mag_a << 32) : mag_a;
                m_d    = mag_b;
                cnt_d  = is_word ? CW'(32) : CW'(XLEN);
                div0_d = (b_eff == '0);
                ovf_d  = is_signed & (a_eff == min_val) & (b_eff == '1);
`ifdef NON_RESTORING_EARLY_OUT_EN
                early_d = (a_eff == '0) | (mag_a < mag_b);
                state_d = (div0_d | ovf_d | early_d) ? S_FIX : S_DIVIDE;
`else
                early_d = 1'b0;
                state_d = S_DIVIDE;
`endif
            end
            S_DIVIDE: begin
                a_d   = a_new;
                q_d   = {q_q[XLEN-2:0], ~a_new[XLEN]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = fix_res;
                otag_d   = tag_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.i_ready && !accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.i_kill) state_d = S_IDLE;
    end

    always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
        if (!i_non_restoring_rstn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            tag_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            aeff_q   <= '0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            early_q  <= 1'b0;
            result_q <= '0;
            otag_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            tag_q    <= tag_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            a_q      <= a_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            aeff_q   <= aeff_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            early_q  <= early_d;
            result_q <= result_d;
            otag_q   <= otag_d;
        end
    end
endmodule

// File: doc/non_restoring_divider_m.md
Name: non_restoring_divider_m

Overview:
- Parametrised successor to the single-shot unsigned divider.
- Multi-cycle non-restoring divider implementing all RV M-extension divide ops: DIV, DIVU, REM, REMU, plus W variants when XLEN=64.
- Uses a valid/ready handshake on both sides, carries a destination tag, supports pipeline kill, and returns RISC-V-defined results for divide-by-zero and signed overflow.
- Sits in the execute stage beside the multiplier, with the writeback arbiter downstream.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the tag carried from request to result (rd index).

Ports:
- i_non_restoring_clk  in  1  clock; all state updates on rising edge.
- i_non_restoring_rstn  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request this cycle.
- i_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_word  in  1  W variant (32-bit op, result sign-extended); ignored when XLEN=32.
- i_dividend  in  XLEN  rs1.
- i_divisor  in  XLEN  rs2.
- i_tag  in  TAG_W  request tag.
- i_kill  in  1  flush: abandon any in-flight or held operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  quotient or remainder, per i_op.
- o_tag  out  TAG_W  tag of the result.
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all internal registers 0; o_valid=0, o_result=0, o_tag=0, o_busy=0. o_ready=1 once reset is released.
- States:
  - IDLE: o_ready=1. On i_valid & o_ready: capture operands, op, word, tag; go to PREP.
  - PREP (1 cycle):
    - Word ops: operands taken from bits [31:0], sign-extended (DIV/REM) or zero-extended (DIVU/REMU).
    - Signed ops: take magnitudes of both operands; record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
    - Detect special cases. Load A=0 (XLEN+1 bits), Q=|a|, M=|b|, count N (32 for word ops, XLEN otherwise).
    - Go to DIVIDE.
  - DIVIDE (exactly N cycles, one quotient bit per cycle):
    - Shift {A,Q} left by 1.
    - If the old A sign bit = 1, A += M; otherwise A -= M.
    - Q[0] = ~new A sign bit. Decrement count; when it reaches 0, go to FIX.
  - FIX (1 cycle):
    - If A is negative, A += M.
    - Apply the recorded signs to Q and A.
    - Select Q (DIV/DIVU) or A (REM/REMU). Word ops: sign-extend result bit 31 to XLEN.
    - Apply special-case override. Register o_result and o_tag; go to DONE.
  - DONE: o_valid=1. On i_ready: go to IDLE. If i_valid is also high in that cycle, accept the new request directly into PREP.
- o_ready = (state==IDLE) | (state==DONE & i_ready).
- Latency: o_valid rises exactly N+2 rising edges after the accepting edge (66 for 64-bit, 34 for W). o_result/o_tag are stable while o_valid=1 and i_ready=0.
- Special cases (results per RISC-V spec):
  - Divisor 0: quotient = all ones; remainder = dividend (word: sign-extended dividend[31:0]).
  - Signed overflow (dividend = most-negative, divisor = -1, at the effective width): quotient = dividend; remainder = 0.
- Kill: i_kill=1 in any state forces IDLE on the next edge and clears o_valid; no result is produced. If i_kill and i_valid are both high in IDLE, the request is dropped.
- A new request is never accepted while PREP, DIVIDE, or FIX is active.

Optional Feature:
- Macro NON_RESTORING_EARLY_OUT_EN.
- Defined: PREP checks for divisor 0, signed overflow, dividend 0, and |a| < |b| (quotient 0, remainder = a). Any hit skips DIVIDE and goes straight to FIX with the result forced; o_valid rises 2 edges after acceptance.
- Undefined: every operation takes fixed latency N+2. Special-case results are still applied in FIX.

Test Plan:
- DIVU 100 / 7, XLEN=64 -> result 14, o_valid exactly 66 edges after accept. REMU 100 / 7 -> 2.
- DIV -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM -7 / 2 -> -1. REM 7 / -2 -> 1.
- DIVW 0x0000_0001_8000_0000 / 1 -> 0xFFFF_FFFF_8000_0000. REMUW 0xFFFF_FFFF_FFFF_FFFF / 0x10 -> 0xF, 34-edge latency.
- DIV by 0 with dividend 5 -> 0xFFFF_FFFF_FFFF_FFFF; REM by 0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0. With the macro defined, each takes 2 edges.
- Backpressure and back-to-back: hold i_ready=0 for 10 cycles -> result and tag stable. Then i_ready=1 with a new i_valid in the same cycle -> new request accepted without an IDLE bubble.
- i_kill at DIVIDE cycle 20 -> IDLE next edge, no o_valid. Deassert rstn mid-DIVIDE -> all outputs 0 immediately, o_ready=1 after release.
